matrix_result_streamer: RTL and testbench
=========================================

Name: matrix_result_streamer

Overview:
- Consumer end of the processor result interface: samples the WIDTH x WIDTH x 32-bit signed `result` matrix when `done` pulses.
- Replays the captured matrix as a row-major stream of 32-bit elements over a valid/ready handshake.
- Sits between the matrix processor and any downstream checker, logger or host port, so the matrix leaves the core one element per beat instead of as a flat bus.

Parameters:
- WIDTH, 2**`WIDTH_BIT (=4), matrix dimension (rows = cols).
- DATA_W, 32, element width in bits; elements are signed two's complement.
- IDX_W, `WIDTH_BIT (=2), row/column index width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_n  in  1  reset, asynchronous assert, active-low.
- done  in  1  single-cycle pulse from processor; `result` is valid in the same cycle.
- result  in  WIDTH*WIDTH*DATA_W  packed signed matrix, [0][0] most significant, row-major.
- busy  out  1  high while a captured matrix is still being streamed.
- out_valid  out  1  element beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  signed element value.
- out_row  out  IDX_W  row index of the current beat.
- out_col  out  IDX_W  column index of the current beat.
- out_last  out  1  high on the [WIDTH-1][WIDTH-1] beat.
- drop_cnt  out  8  saturating count of `done` pulses ignored while busy.
- frame_cnt  out  16  count of fully streamed matrices; wraps at 65535->0.

Behaviour:
- Reset (RST_n=0, async):
  - state=IDLE; snapshot cleared to 0.
  - busy=0, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, drop_cnt=0, frame_cnt=0.
  - Reset mid-stream aborts the frame; no further beats of it appear, and frame_cnt is not incremented.
- States: IDLE, STREAM.
- IDLE:
  - done=1 at edge k: snapshot<=result, row=col=0, go STREAM.
  - out_valid=1 and busy=1 from edge k, i.e. first beat visible in cycle k+1. Latency done->first valid = 1 cycle.
- STREAM:
  - out_data = snapshot[row][col].
  - Handshake occurs when out_valid & out_ready at a rising edge.
  - On handshake: col increments; at col=WIDTH-1, col->0 and row increments.
  - Without handshake: out_data, out_row, out_col and out_last hold stable (AXI-style stability rule).
- out_last = (row==WIDTH-1 && col==WIDTH-1) while out_valid.
- Handshake on the last beat:
  - frame_cnt+1.
  - If done=1 in the same cycle: recapture, row=col=0, stay STREAM (back-to-back, no bubble).
  - Otherwise go IDLE; out_valid=0 and busy=0 next cycle.
- done=1 in STREAM other than on the last-beat handshake:
  - Snapshot unchanged; drop_cnt+1, saturating at 255.
- Back-to-back frames with no drops require a done spacing of at least WIDTH*WIDTH cycles with out_ready held high.
- With out_ready constantly 1, a frame occupies exactly WIDTH*WIDTH cycles of out_valid.
- Arithmetic:
  - No arithmetic on data; elements pass bit-exact, sign preserved.
  - Index counters are IDX_W bits, so WIDTH must be a power of two.
- out_ready while out_valid=0: ignored.
- X on `result` outside a done cycle: must not propagate.

Decomposition:
- Shared constants header (existing CONSTANT.v):
  - `WIDTH_BIT`
  - new `DATA_W` define
  - state encodings `ST_IDLE`, `ST_STREAM`.
- Sub-module `matrix_index_counter`:
  - row/col counter with enable, clear, and `at_last` output.
  - Reused by a future matrix loader on the input side.
- Snapshot register and state machine live in the top module.

Test Plan:
- Directed scenarios assume WIDTH=4.
- Basic stream:
  - Stimulus: result[i][j]=4*i+j+1, one done pulse, out_ready=1.
  - Required: 16 beats with values 1..16 in order; row/col go (0,0)..(3,3); out_last only on value 16; busy low 17 cycles after done; frame_cnt=1.
- Backpressure:
  - Stimulus: same matrix, out_ready toggling 1,0,1,0...
  - Required: each beat held stable across the 0 cycles; 16 beats total in 31 cycles; no duplicated or skipped values.
- Drop while busy:
  - Stimulus: second done with result all 99 asserted during beat 5.
  - Required: stream continues with 6..16, not 99; drop_cnt=1; frame_cnt=1.
- Back-to-back:
  - Stimulus: second done, matrix all -5, coincident with the last-beat handshake.
  - Required: next cycle out_valid=1, out_data=-5 (0xFFFFFFFB), row=col=0; no idle bubble; drop_cnt=0.
- Reset mid-stream:
  - Stimulus: RST_n=0 asynchronously during beat 7.
  - Required: all outputs 0 immediately; after release, out_valid stays 0 until the next done; frame_cnt=0.
- Saturation:
  - Stimulus: 300 done pulses while stalled with out_ready=0.
  - Required: drop_cnt=255, held; out_data still shows the first captured element.

Source files
------------

// File: rtl/matrix_result_streamer_pkg.sv
// Shared constants for the matrix result streamer and its index counter.
// Holds the matrix geometry, the element width, the streamer state encoding
// and a helper that pulls one element out of the packed row-major matrix.
package matrix_result_streamer_pkg;

   localparam int WIDTH_BIT = 2;
   localparam int WIDTH     = 1 << WIDTH_BIT;
   localparam int DATA_W    = 32;
   localparam int IDX_W     = WIDTH_BIT;
   localparam int CELLS     = WIDTH * WIDTH;
   localparam int FLAT_W    = 2 * IDX_W;
   localparam int MAT_W     = CELLS * DATA_W;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_e;

   // Element [row][col] lives at flat index row*WIDTH+col, i.e. {row,col}.
   // Element 0 occupies the most significant DATA_W bits of the bus.
   function automatic logic [DATA_W-1:0] get_elem(input logic [MAT_W-1:0]  mat,
                                                   input logic [FLAT_W-1:0] idx);
      logic [FLAT_W-1:0] rev;
      rev = FLAT_W'(CELLS - 1) - idx;
      return mat[int'(rev) * DATA_W +: DATA_W];
   endfunction

endpackage

// File: rtl/matrix_result_streamer_index_counter.sv
// matrix_index_counter: row/column walker over a WIDTH x WIDTH matrix.
// Ports:
//   CLK, RST_n : clock, asynchronous active-low reset
//   clr        : force row=col=0 (wins over en)
//   en         : advance one element in row-major order, wrapping to (0,0)
//   row, col   : current position
//   at_last    : position is [WIDTH-1][WIDTH-1]
module matrix_index_counter
   import matrix_result_streamer_pkg::*;
(
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             clr,
   input  logic             en,
   output logic [IDX_W-1:0] row,
   output logic [IDX_W-1:0] col,
   output logic             at_last
);

   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

   // Row-major position register; IDX_W-bit arithmetic wraps naturally.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         row <= '0;
         col <= '0;
      end else if (clr) begin
         row <= '0;
         col <= '0;
      end else if (en) begin
         if (col == IDX_MAX) begin
            col <= '0;
            row <= row + IDX_W'(1);
         end else begin
            col <= col + IDX_W'(1);
         end
      end else begin
         row <= row;
         col <= col;
      end
   end

   assign at_last = (row == IDX_MAX) && (col == IDX_MAX);

endmodule

// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer: captures the processor's WIDTH x WIDTH result
// matrix on a done pulse and replays it row-major, one element per
// valid/ready beat.
// Ports:
//   CLK, RST_n         : clock, asynchronous active-low reset
//   done, result       : capture strobe and packed matrix ([0][0] at MSB)
//   busy               : a captured matrix is still being streamed
//   out_valid/out_ready: beat handshake
//   out_data           : element value, bit-exact
//   out_row, out_col   : element position
//   out_last           : final element of the matrix
//   drop_cnt           : done pulses ignored while busy (saturates at 255)
//   frame_cnt          : matrices fully streamed (wraps)
module matrix_result_streamer
   import matrix_result_streamer_pkg::*;
(
   input  logic              CLK,
   input  logic              RST_n,
   input  logic              done,
   input  logic [MAT_W-1:0]  result,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_row,
   output logic [IDX_W-1:0]  out_col,
   output logic              out_last,
   output logic [7:0]        drop_cnt,
   output logic [15:0]       frame_cnt
);

   state_e             state_r;
   logic [MAT_W-1:0]   snap_r;
   logic               hs_s;
   logic               fin_s;
   logic               capture_s;
   logic               cnt_en_s;
   logic               at_last_s;
   logic [FLAT_W-1:0]  next_idx_s;

   assign hs_s       = out_valid & out_ready;
   assign fin_s      = hs_s & at_last_s;
   // A capture happens from IDLE, or chained onto the last-beat handshake.
   assign capture_s  = done & ((state_r == ST_IDLE) | fin_s);
   // On a last-beat handshake the counter wraps to (0,0) by itself.
   assign cnt_en_s   = hs_s & ~capture_s;
   assign next_idx_s = {out_row, out_col} + FLAT_W'(1);

   matrix_index_counter u_idx (
      .CLK     (CLK),
      .RST_n   (RST_n),
      .clr     (capture_s),
      .en      (cnt_en_s),
      .row     (out_row),
      .col     (out_col),
      .at_last (at_last_s)
   );

   // Stream FSM: snapshot, registered beat outputs and status counters.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_r   <= ST_IDLE;
         snap_r    <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         drop_cnt  <= 8'd0;
         frame_cnt <= 16'd0;
      end else begin
         if (capture_s) begin
            // Only a capture ever samples result, so garbage on the bus
            // between done pulses cannot reach the outputs.
            snap_r    <= result;
            out_data  <= get_elem(result, FLAT_W'(0));
            out_valid <= 1'b1;
            busy      <= 1'b1;
            out_last  <= (CELLS == 1) ? 1'b1 : 1'b0;
            state_r   <= ST_STREAM;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  state_r <= ST_IDLE;
               end
               ST_STREAM: begin
                  if (fin_s) begin
                     state_r   <= ST_IDLE;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     out_last  <= 1'b0;
                  end else if (hs_s) begin
                     out_data <= get_elem(snap_r, next_idx_s);
                     out_last <= (next_idx_s == {FLAT_W{1'b1}});
                  end else begin
                     out_data <= out_data;
                  end
               end
               default: begin
                  state_r   <= ST_IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  out_last  <= 1'b0;
               end
            endcase
         end

         if (fin_s) begin
            frame_cnt <= frame_cnt + 16'd1;
         end else begin
            frame_cnt <= frame_cnt;
         end

         if (done && (state_r == ST_STREAM) && !fin_s && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
         end else begin
            drop_cnt <= drop_cnt;
         end
      end
   end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Self-checking bench for matrix_result_streamer (WIDTH=4, DATA_W=32).
// A frame-level model (active flag, beat number, captured element array)
// predicts every output each cycle; directed scenarios add literal checks.
module tb_matrix_result_streamer;

   logic         CLK = 1'b0;
   logic         RST_n = 1'b1;
   logic         done = 1'b0;
   logic [511:0] result = '0;
   logic         busy;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [31:0]  out_data;
   logic [1:0]   out_row;
   logic [1:0]   out_col;
   logic         out_last;
   logic [7:0]   drop_cnt;
   logic [15:0]  frame_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   // Elements currently presented on result, [0] = element [0][0].
   logic [31:0] drv [16];

   // Model state.
   bit          m_active = 1'b0;
   int          m_k      = 0;
   int          m_drop   = 0;
   int          m_frames = 0;
   logic [31:0] m_mat [16];

   matrix_result_streamer dut (
      .CLK       (CLK),
      .RST_n     (RST_n),
      .done      (done),
      .result    (result),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_col   (out_col),
      .out_last  (out_last),
      .drop_cnt  (drop_cnt),
      .frame_cnt (frame_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic pack();
      for (int i = 0; i < 16; i++) result[(15 - i) * 32 +: 32] = drv[i];
   endtask

   task automatic fill_seq();
      for (int i = 0; i < 16; i++) drv[i] = 32'(i + 1);
      pack();
   endtask

   task automatic fill_const(input logic [31:0] v);
      for (int i = 0; i < 16; i++) drv[i] = v;
      pack();
   endtask

   task automatic garbage();
      for (int i = 0; i < 16; i++) drv[i] = $urandom;
      pack();
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      done      = 1'b0;
      out_ready = 1'b0;
      RST_n     = 1'b0;
      tick();
      tick();
      RST_n = 1'b1;
      tick();
   endtask

   // Pulse done for one edge with the currently packed matrix, then scramble result.
   task automatic pulse_done();
      done = 1'b1;
      tick();
      done = 1'b0;
      garbage();
   endtask

   // Frame-level reference: which beat is on offer and what it must carry.
   always @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         m_active = 1'b0;
         m_k      = 0;
         m_drop   = 0;
         m_frames = 0;
      end else begin
         bit hs, fin;
         hs  = m_active && out_ready;
         fin = hs && (m_k == 15);
         if (hs) m_k = m_k + 1;
         if (fin) m_frames = (m_frames + 1) % 65536;
         if (done && (!m_active || fin)) begin
            for (int i = 0; i < 16; i++) m_mat[i] = drv[i];
            m_k      = 0;
            m_active = 1'b1;
         end else begin
            if (done && m_active && m_drop < 255) m_drop = m_drop + 1;
            if (fin) m_active = 1'b0;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge CLK) begin
      if (cmp_en) begin
         chk("cmp_valid", out_valid, m_active);
         chk("cmp_busy", busy, m_active);
         chk("cmp_drop", drop_cnt, m_drop);
         chk("cmp_frame", frame_cnt, m_frames);
         if (m_active) begin
            chk("cmp_data", out_data, m_mat[m_k]);
            chk("cmp_row", out_row, m_k / 4);
            chk("cmp_col", out_col, m_k % 4);
            chk("cmp_last", out_last, m_k == 15);
         end
      end
   end

   initial begin
      int cyc, beats;
      garbage();
      #1 RST_n = 1'b0;
      do_reset();

      // Reset state.
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", out_data, 0);
      chk("rst_row", out_row, 0);
      chk("rst_col", out_col, 0);
      chk("rst_last", out_last, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_frame", frame_cnt, 0);
      cmp_en = 1'b1;

      // Basic stream.
      fill_seq();
      out_ready = 1'b1;
      pulse_done();
      for (int i = 0; i < 16; i++) begin
         chk("basic_valid", out_valid, 1);
         chk("basic_data", out_data, i + 1);
         chk("basic_row", out_row, i / 4);
         chk("basic_col", out_col, i % 4);
         chk("basic_last", out_last, i == 15);
         tick();
      end
      chk("basic_busy_end", busy, 0);
      chk("basic_valid_end", out_valid, 0);
      chk("basic_frame", frame_cnt, 1);

      // Backpressure with ready toggling 1,0,1,0...
      do_reset();
      fill_seq();
      pulse_done();
      cyc = 0;
      beats = 0;
      while (beats < 16 && cyc < 100) begin
         out_ready = (cyc % 2 == 0);
         chk("bp_valid", out_valid, 1);
         chk("bp_data", out_data, beats + 1);
         if (out_ready) beats++;
         tick();
         cyc++;
      end
      chk("bp_beats", beats, 16);
      chk("bp_cycles", cyc, 31);
      chk("bp_valid_end", out_valid, 0);
      chk("bp_frame", frame_cnt, 1);

      // Drop while busy: second done during beat 5.
      do_reset();
      fill_seq();
      out_ready = 1'b1;
      pulse_done();
      for (int i = 0; i < 16; i++) begin
         chk("drop_data", out_data, i + 1);
         if (i == 4) begin
            done = 1'b1;
            fill_const(32'd99);
         end else if (i == 5) begin
            done = 1'b0;
            garbage();
         end
         tick();
      end
      chk("drop_cnt", drop_cnt, 1);
      chk("drop_frame", frame_cnt, 1);

      // Back-to-back: new done on the last-beat handshake.
      do_reset();
      fill_seq();
      out_ready = 1'b1;
      pulse_done();
      for (int i = 0; i < 16; i++) begin
         chk("b2b_data", out_data, i + 1);
         if (i == 15) begin
            done = 1'b1;
            fill_const(32'hFFFF_FFFB);
         end
         tick();
      end
      done = 1'b0;
      garbage();
      chk("b2b_valid", out_valid, 1);
      chk("b2b_busy", busy, 1);
      chk("b2b_data", out_data, 32'hFFFF_FFFB);
      chk("b2b_row", out_row, 0);
      chk("b2b_col", out_col, 0);
      chk("b2b_drop", drop_cnt, 0);
      chk("b2b_frame", frame_cnt, 1);
      repeat (16) tick();
      chk("b2b_frame2", frame_cnt, 2);

      // Reset mid-stream during beat 7.
      do_reset();
      fill_seq();
      out_ready = 1'b1;
      pulse_done();
      repeat (6) tick();
      chk("mid_data_pre", out_data, 7);
      #2 RST_n = 1'b0;
      #1;
      chk("mid_valid", out_valid, 0);
      chk("mid_busy", busy, 0);
      chk("mid_data", out_data, 0);
      chk("mid_row", out_row, 0);
      chk("mid_col", out_col, 0);
      chk("mid_last", out_last, 0);
      chk("mid_frame", frame_cnt, 0);
      tick();
      tick();
      RST_n = 1'b1;
      repeat (5) tick();
      chk("mid_valid_after", out_valid, 0);
      chk("mid_frame_after", frame_cnt, 0);

      // Saturation: done held for 300 cycles while stalled.
      do_reset();
      fill_seq();
      out_ready = 1'b0;
      done = 1'b1;
      tick();
      repeat (300) begin
         garbage();
         tick();
      end
      done = 1'b0;
      chk("sat_drop", drop_cnt, 255);
      chk("sat_data", out_data, 1);
      chk("sat_valid", out_valid, 1);
      repeat (3) tick();
      chk("sat_drop_hold", drop_cnt, 255);

      // Randomized traffic.
      do_reset();
      repeat (3000) begin
         garbage();
         done      = ($urandom_range(0, 11) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      done = 1'b0;
      out_ready = 1'b1;
      repeat (40) tick();
      chk("rand_idle", out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
